priority_enc_rr: RTL and testbench
==================================

// Module: priority_enc_rr
// PURPOSE
//  Parametrised, registered N-to-log2(N) request encoder; successor to the fixed 8-to-3 combinational encoder.
//  Latches request pulses into a pending mask; offers one index at a time on a valid/ready output.
//  Arbitration is selectable: fixed LSB-first, fixed MSB-first or round-robin.
//  All-zero input is a defined state (out_valid=0), never X/Z. Sits between interrupt/event sources and a single consumer.
// PARAMETERS
//  N      8  number of request lines, legal 2..64
//  IDX_W  $clog2(N)  width of encoded index (derived; do not override)
//  MODE   0  0=fixed LSB-first (lowest index wins), 1=fixed MSB-first, 2=round-robin
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   N      request bits, sampled every edge; pulse or level
//  flush      in   1      synchronous clear of pending mask and output
//  out_ready  in   1      consumer accepts out_idx this edge
//  out_valid  out  1      out_idx holds a granted request
//  out_idx    out  IDX_W  encoded index of granted request
//  pending    out  N      registered pending mask (excludes nothing; includes offered bit)
//  drop       out  1      one-cycle pulse: a req hit an already-pending bit (merged)
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, out_valid=0, out_idx=0, drop=0, rr_ptr=0, state=IDLE. Takes effect immediately, mid-transfer included.
//  hs = out_valid & out_ready; clr = hs ? onehot(out_idx) : 0.
//  pending_next = (pending & ~clr) | req; flush=1 forces pending_next=0, out_valid=0 (flush beats req and hs).
//  drop_next = |(req & pending & ~clr); a req on the bit being cleared this edge re-pends, no drop.
//  cand = pending & ~clr (registered bits only; req reaches output one edge later).
//  Selection over cand: MODE0 lowest set bit; MODE1 highest set bit; MODE2 first set bit scanning upward from rr_ptr, wrapping N-1 to 0.
//  rr_ptr updates only on hs: rr_ptr <= (out_idx==N-1) ? 0 : out_idx+1. Unused when MODE!=2.
//  State machine (2 states):
//   IDLE:  out_valid=0. If cand!=0: load out_idx=sel(cand), out_valid=1, go VALID.
//   VALID: out_valid=1. If !out_ready: hold out_idx and out_valid stable (no change, even if higher-priority req arrives).
//          If out_ready & cand!=0: load next sel(cand), stay VALID (back-to-back, 1 grant/cycle).
//          If out_ready & cand==0: out_valid=0, go IDLE.
//  Latency: req at edge E0 -> pending at E0 -> out_valid/out_idx at E1 (2 edges req->valid when IDLE).
//  Offered bit stays set in pending until its handshake edge.
//  All arithmetic in IDX_W bits; for non-power-of-2 N the index never exceeds N-1.
// STRUCTURE
//  Package priority_enc_pkg: MODE_LSB/MODE_MSB/MODE_RR localparams; state enum IDLE/VALID; onehot/clog2 helper functions.
//  Sub-module pe_select (combinational): inputs mask[N], base[IDX_W], mode; outputs idx[IDX_W], any.
//   Round-robin via doubled-mask scan from base. Top holds the registers and FSM only.
// TESTING (N=8 unless noted; assertions: out_idx stable while out_valid&!out_ready; out_idx<N)
//  Reset: rst_n=0 mid-VALID with pending=8'hFF -> same cycle out_valid=0, pending=0, drop=0, out_idx=0.
//  Fixed LSB, req=8'b1010_0100 one cycle, out_ready=1 -> out_idx 2,5,7 on consecutive edges, then out_valid=0.
//  MODE1 same stimulus -> 7,5,2. MODE2 N=5, req=5'h1F held, ready=1 -> 0,1,2,3,4,0 (wrap).
//  Backpressure: req=8'h01, ready=0 for 4 cycles, then req=8'h80 -> out_idx stays 0, no reorder. req[0] again -> drop pulse 1 cycle.
//  Re-request on clear edge: hs on idx 3 with req[3]=1 same edge -> pending[3]=1, drop=0, idx 3 re-offered.
//  Flush with req=8'h10 and hs same edge -> pending=0, out_valid=0 next edge; zero input -> out_valid stays 0, no X.

Source files
------------

// File: rtl/priority_enc_pkg.sv
// Shared definitions for the registered request encoder: arbitration modes,
// the offer FSM state type and small helpers used to size and decode indices.
package priority_enc_pkg;

    localparam logic [1:0] MODE_LSB = 2'd0;
    localparam logic [1:0] MODE_MSB = 2'd1;
    localparam logic [1:0] MODE_RR  = 2'd2;

    localparam int MAX_N = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    // Index width for n request lines; n is at most MAX_N, so six bits suffice.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input logic [5:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_enc_rr_if.sv
// Request/grant bundle between event sources, the encoder and its single consumer.
interface priority_enc_rr_if #(
    parameter int N = 8
) ();
    localparam int IDX_W = priority_enc_pkg::clog2(N);

    // out_idx is transferred on a rising edge where out_valid & out_ready are both 1;
    // while out_valid is high and out_ready is low, out_idx and out_valid hold steady,
    // and out_valid never drops without a transfer except on flush or reset.
    logic [N-1:0]     req;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [N-1:0]     pending;
    logic             drop;

    modport master (
        output req, flush, out_ready,
        input  out_valid, out_idx, pending, drop
    );

    modport slave (
        input  req, flush, out_ready,
        output out_valid, out_idx, pending, drop
    );

endinterface

// File: rtl/pe_select.sv
// Combinational selector: picks one set bit of mask by lowest index, highest
// index, or first set bit at or above base with wrap-around.
module pe_select
    import priority_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = clog2(N),
    localparam int SW    = IDX_W + 1
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] base,
    input  logic [1:0]       mode,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [SW-1:0]  pos;
    logic           found;

    assign any = |mask;
    // Two copies back to back let the wrap-around scan run as a plain upward walk.
    assign dbl = {mask, mask};

    always_comb begin
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        case (mode)
            MODE_MSB: begin
                for (int i = 0; i < N; i++) begin
                    if (mask[i]) idx = IDX_W'(i);
                end
            end
            MODE_RR: begin
                for (int k = 0; k < N; k++) begin
                    pos = {1'b0, base} + SW'(k);
                    if (!found && dbl[pos]) begin
                        found = 1'b1;
                        idx   = (pos >= SW'(N)) ? IDX_W'(pos - SW'(N)) : IDX_W'(pos);
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (mask[i]) idx = IDX_W'(i);
                end
            end
        endcase
    end

endmodule

// File: rtl/priority_enc_rr.sv
// Registered request encoder: latches request pulses into a pending mask and
// offers one granted index at a time to a single consumer over valid/ready.
module priority_enc_rr
    import priority_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    priority_enc_rr_if.slave pe_bus,
    output state_e           state_o
);

    localparam int IDX_W = clog2(N);

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             drop_q, drop_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             hs;
    logic [N-1:0]     clr;
    logic [N-1:0]     cand;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    assign hs   = out_valid_q & pe_bus.out_ready;
    assign clr  = hs ? N'(onehot(6'(out_idx_q))) : '0;
    // Only registered bits compete; a request arriving this edge is seen next edge.
    assign cand = pending_q & ~clr;

    pe_select #(
        .N (N)
    ) u_sel (
        .mask (cand),
        .base (rr_ptr_q),
        .mode (2'(MODE)),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        pending_d   = (pending_q & ~clr) | pe_bus.req;
        // A request on the bit being granted this edge simply re-pends; it is not a merge.
        drop_d      = |(pe_bus.req & pending_q & ~clr);

        if (hs) begin
            rr_ptr_d = (out_idx_q == IDX_W'(N - 1)) ? '0 : out_idx_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (sel_any) begin
                    out_idx_d   = sel_idx;
                    out_valid_d = 1'b1;
                    state_d     = VALID;
                end
            end
            VALID: begin
                out_valid_d = 1'b1;
                if (pe_bus.out_ready) begin
                    if (sel_any) begin
                        out_idx_d = sel_idx;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Flush outranks both new requests and a grant completing on the same edge.
        if (pe_bus.flush) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            drop_d      = 1'b0;
            rr_ptr_d    = rr_ptr_q;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            drop_q      <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            drop_q      <= drop_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign pe_bus.out_valid = out_valid_q;
    assign pe_bus.out_idx   = out_idx_q;
    assign pe_bus.pending   = pending_q;
    assign pe_bus.drop      = drop_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_priority_enc_rr.sv
// Bench for priority_enc_rr: three instances (LSB N=8, MSB N=8, round-robin N=5)
// driven with directed vectors; granted indices are checked against an expected queue.
module tb_priority_enc_rr;
    import priority_enc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_enc_rr_if #(.N(8)) if0 ();
    priority_enc_rr_if #(.N(8)) if1 ();
    priority_enc_rr_if #(.N(5)) if2 ();
    state_e st0, st1, st2;

    priority_enc_rr #(.N(8), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .pe_bus(if0), .state_o(st0));
    priority_enc_rr #(.N(8), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .pe_bus(if1), .state_o(st1));
    priority_enc_rr #(.N(5), .MODE(2)) dut2 (.clk(clk), .rst_n(rst_n), .pe_bus(if2), .state_o(st2));

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];
    logic [2:0] exp_q2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the next expected index of that instance.
    logic       hold0 = 1'b0;
    logic [2:0] held0 = '0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 = 1'b0;
        end else begin
            if (hold0) begin
                check("hold_valid0", if0.out_valid, 1);
                check("hold_idx0", if0.out_idx, held0);
            end
            hold0 = if0.out_valid & ~if0.out_ready;
            held0 = if0.out_idx;
            if (if2.out_valid) check("idx_range2", if2.out_idx < 3'd5, 1);

            if (if0.out_valid && if0.out_ready) begin
                if (exp_q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb0_unexpected: got idx %0d, expected no grant", if0.out_idx);
                end else check("sb0_idx", if0.out_idx, exp_q0.pop_front());
            end
            if (if1.out_valid && if1.out_ready) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1_unexpected: got idx %0d, expected no grant", if1.out_idx);
                end else check("sb1_idx", if1.out_idx, exp_q1.pop_front());
            end
            if (if2.out_valid && if2.out_ready) begin
                if (exp_q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb2_unexpected: got idx %0d, expected no grant", if2.out_idx);
                end else check("sb2_idx", if2.out_idx, exp_q2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    endtask

    initial begin
        if0.req = '0; if0.flush = 1'b0; if0.out_ready = 1'b0;
        if1.req = '0; if1.flush = 1'b0; if1.out_ready = 1'b0;
        if2.req = '0; if2.flush = 1'b0; if2.out_ready = 1'b0;

        // Power-on reset state
        repeat (2) tick();
        check("rst_valid0", if0.out_valid, 0);
        check("rst_pending0", if0.pending, 0);
        check("rst_drop0", if0.drop, 0);
        check("rst_state0", st0, IDLE);
        check("rst_valid2", if2.out_valid, 0);
        rst_n = 1'b1;
        tick();

        // LSB-first: 2,5,7 back to back
        if0.req = 8'hA4; if0.out_ready = 1'b1;
        exp_q0.push_back(3'd2); exp_q0.push_back(3'd5); exp_q0.push_back(3'd7);
        tick();
        if0.req = '0;
        check("lsb_pending", if0.pending, 8'hA4);
        check("lsb_latency_valid", if0.out_valid, 0);
        tick();
        check("lsb_first_valid", if0.out_valid, 1);
        check("lsb_first_idx", if0.out_idx, 2);
        drain(10);
        tick();
        check("lsb_end_valid", if0.out_valid, 0);
        check("lsb_end_pending", if0.pending, 0);

        // MSB-first: 7,5,2
        if1.req = 8'hA4; if1.out_ready = 1'b1;
        exp_q1.push_back(3'd7); exp_q1.push_back(3'd5); exp_q1.push_back(3'd2);
        tick();
        if1.req = '0;
        check("msb_pending", if1.pending, 8'hA4);
        tick();
        check("msb_first_idx", if1.out_idx, 7);
        drain(10);
        tick();
        check("msb_end_valid", if1.out_valid, 0);
        if1.out_ready = 1'b0;

        // Round-robin N=5, all requests held six edges: wraps 4 -> 0
        if2.req = 5'h1F; if2.out_ready = 1'b1;
        exp_q2.push_back(3'd0); exp_q2.push_back(3'd1); exp_q2.push_back(3'd2);
        exp_q2.push_back(3'd3); exp_q2.push_back(3'd4); exp_q2.push_back(3'd0);
        exp_q2.push_back(3'd1); exp_q2.push_back(3'd2); exp_q2.push_back(3'd3);
        tick();
        tick();
        check("rr_merge_drop", if2.drop, 1);
        repeat (4) tick();
        if2.req = '0;
        drain(20);
        tick();
        check("rr_end_valid", if2.out_valid, 0);
        check("rr_end_pending", if2.pending, 0);

        // Backpressure: offered index holds, later higher request does not reorder
        if0.req = 8'h01; if0.out_ready = 1'b0;
        tick();
        if0.req = '0;
        tick();
        check("bp_valid", if0.out_valid, 1);
        check("bp_idx", if0.out_idx, 0);
        repeat (3) tick();
        if0.req = 8'h80;
        tick();
        if0.req = '0;
        check("bp_pending", if0.pending, 8'h81);
        check("bp_idx_hold", if0.out_idx, 0);
        if0.req = 8'h01;
        tick();
        if0.req = '0;
        check("bp_drop_pulse", if0.drop, 1);
        check("bp_pending_merge", if0.pending, 8'h81);
        tick();
        check("bp_drop_clear", if0.drop, 0);
        exp_q0.push_back(3'd0); exp_q0.push_back(3'd7);
        if0.out_ready = 1'b1;
        drain(10);
        tick();
        check("bp_end_valid", if0.out_valid, 0);

        // Re-request on the clearing edge re-pends without a drop
        if0.req = 8'h08; if0.out_ready = 1'b0;
        tick();
        if0.req = '0;
        tick();
        check("rereq_idx", if0.out_idx, 3);
        exp_q0.push_back(3'd3); exp_q0.push_back(3'd3);
        if0.req = 8'h08; if0.out_ready = 1'b1;
        tick();
        if0.req = '0;
        check("rereq_pending", if0.pending, 8'h08);
        check("rereq_drop", if0.drop, 0);
        tick();
        check("rereq_reoffer_valid", if0.out_valid, 1);
        check("rereq_reoffer_idx", if0.out_idx, 3);
        drain(10);
        tick();
        check("rereq_end_pending", if0.pending, 0);

        // Flush beats a new request and a handshake on the same edge
        if0.req = 8'h02; if0.out_ready = 1'b0;
        tick();
        if0.req = '0;
        tick();
        check("flush_pre_idx", if0.out_idx, 1);
        exp_q0.push_back(3'd1);
        if0.flush = 1'b1; if0.req = 8'h10; if0.out_ready = 1'b1;
        tick();
        if0.flush = 1'b0; if0.req = '0;
        check("flush_pending", if0.pending, 0);
        check("flush_valid", if0.out_valid, 0);
        check("flush_state", st0, IDLE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zero_valid", if0.out_valid, 0);
            check("zero_idx_known", $isunknown(if0.out_idx), 0);
        end
        drain(5);

        // Asynchronous reset mid-VALID with everything pending
        if0.req = 8'hFF; if0.out_ready = 1'b0;
        if1.req = 8'hFF; if1.out_ready = 1'b0;
        tick();
        tick();
        if0.req = '0; if1.req = '0;
        check("pre_rst_pending0", if0.pending, 8'hFF);
        check("pre_rst_drop0", if0.drop, 1);
        check("pre_rst_idx1", if1.out_idx, 7);
        rst_n = 1'b0;
        #1;
        check("arst_valid0", if0.out_valid, 0);
        check("arst_pending0", if0.pending, 0);
        check("arst_drop0", if0.drop, 0);
        check("arst_idx0", if0.out_idx, 0);
        check("arst_valid1", if1.out_valid, 0);
        check("arst_idx1", if1.out_idx, 0);
        check("arst_pending1", if1.pending, 0);
        check("arst_state1", st1, IDLE);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_valid0", if0.out_valid, 0);
        check("post_rst_valid1", if1.out_valid, 0);

        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);
        check("q2_empty", exp_q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
